sdram_bank_sched: RTL and testbench
===================================

SDRAM_BANK_SCHED -- requirements
Module: sdram_bank_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_ref  input  1  SDRAM controller clock; all logic is on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 sdram_init_done  input  1  level; while low, all frame events are ignored.
REQ-005 frame_write_done  input  1  one-cycle pulse; the writer has finished one frame in wr_bank.
REQ-006 rd_frame_req  input  1  one-cycle pulse, already in clk_ref domain; the reader starts a new frame.
REQ-007 wr_bank  output  2  SDRAM bank the writer targets.
REQ-008 rd_bank  output  2  SDRAM bank the reader targets.
REQ-009 wr_load  output  1  one-cycle pulse; resets the writer address to wr_addr.
REQ-010 rd_load  output  1  one-cycle pulse; resets the reader address to rd_addr.
REQ-011 wr_hold  output  1  level; the writer must not start a frame while high.
REQ-012 repeat_cnt  output  8  saturating count of reader frames that re-displayed the old bank.
REQ-013 drop_cnt  output  8  saturating count of completed frames overwritten before display.
REQ-014 seq_err  output  1  sticky; frame_write_done arrived while wr_hold=1.

Function
REQ-015 Bank roles SHALL be registers W (writer), R (reader) and, in triple mode, S (spare), plus flag n_vld (a completed, undisplayed frame is pending).
REQ-016 In triple mode, the pending frame SHALL reside in S when n_vld=1.
REQ-017 Events SHALL be sampled only when sdram_init_done=1; outputs SHALL update on the clock edge after the sampled event (latency 1).
REQ-018 States: WAIT_INIT -> ACTIVE on sdram_init_done=1; ACTIVE -> HOLD (double mode only) on write done; HOLD -> ACTIVE on rd_frame_req.
REQ-019 On WAIT_INIT -> ACTIVE, wr_load and rd_load SHALL each pulse once.
REQ-020 Triple, write done only: S<=W, W<=old S, n_vld<=1, wr_load pulse.
REQ-021 Triple, write done only: drop_cnt SHALL increment if the old n_vld=1.
REQ-022 Triple, read request only, n_vld=1: R<=S, S<=old R, n_vld<=0, rd_load pulse.
REQ-023 Triple, read request only, n_vld=0: banks unchanged, rd_load pulse, repeat_cnt increments.
REQ-024 Triple, both in the same cycle: W<=old S, R<=old W, S<=old R, n_vld<=0, both loads pulse.
REQ-025 Triple, both in the same cycle: drop_cnt SHALL increment if the old n_vld=1.
REQ-026 Double, ACTIVE, write done only: n_vld<=1, wr_hold<=1, go to HOLD, no wr_load.
REQ-027 Double, read request with n_vld=1 (HOLD): swap W and R, n_vld<=0, wr_hold<=0, both loads pulse, go to ACTIVE.
REQ-028 Double, ACTIVE, read request with n_vld=0: banks unchanged, rd_load pulse, repeat_cnt increments.
REQ-029 Double, ACTIVE, both in the same cycle: immediate swap as REQ-027; no HOLD entry.
REQ-030 Double, write done in HOLD: ignored and seq_err<=1; a simultaneous read request SHALL still complete the swap.
REQ-031 repeat_cnt and drop_cnt SHALL hold at 255 once reached; drop_cnt SHALL stay 0 in double mode.
REQ-032 The 2-bit bank values SHALL take only 0, 1 or 2; bank 3 SHALL never be driven.
REQ-033 sdram_init_done falling in ACTIVE or HOLD SHALL return the block to WAIT_INIT with bank roles kept, n_vld<=0 and wr_hold<=0.

Reset
REQ-034 In reset: W=0, R=1, S=2 (wr_bank=0, rd_bank=1), n_vld=0, state WAIT_INIT.
REQ-035 In reset: wr_load=0, rd_load=0, wr_hold=0, repeat_cnt=0, drop_cnt=0, seq_err=0.
REQ-036 Reset asserted mid-operation SHALL override any same-cycle event; no load pulse is emitted in that cycle.

Configuration
REQ-037 Macro SDRAM_BANK_SCHED_TRIPLE_BUF_EN defined: triple-buffer mode, banks 0-2 used and wr_hold is constant 0.
REQ-038 Macro SDRAM_BANK_SCHED_TRIPLE_BUF_EN undefined: double-buffer mode, banks 0-1 used and the S register is not built.

Verification
REQ-039 Reset, init_done=1 -> one-cycle wr_load and rd_load pulses, wr_bank=0, rd_bank=1.
REQ-040 Triple: write done, then read request 5 cycles later -> wr_bank=2; rd_bank=0; repeat_cnt=0.
REQ-041 Triple: three write dones, no read request -> drop_cnt=2, and the next read request gets the last completed bank.
REQ-042 Triple: write done and read request in the same cycle from reset -> wr_bank=2, rd_bank=0, drop_cnt=0.
REQ-043 Double: write done -> wr_hold=1; second write done -> seq_err=1; read request -> wr_bank=1, rd_bank=0, wr_hold=0.
REQ-044 Any mode: 300 read requests with no writes -> repeat_cnt saturates at 255; reset mid-stream -> all counters 0.

Source files
------------

// File: rtl/sdram_bank_sched.sv
// Frame-buffer bank scheduler between an SDRAM writer and reader.
// Define SDRAM_BANK_SCHED_TRIPLE_BUF_EN for triple buffering; the default build is double buffering.
module sdram_bank_sched (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       sdram_init_done,
  input  logic       frame_write_done,
  input  logic       rd_frame_req,
  output logic [1:0] wr_bank,
  output logic [1:0] rd_bank,
  output logic       wr_load,
  output logic       rd_load,
  output logic       wr_hold,
  output logic [7:0] repeat_cnt,
  output logic [7:0] drop_cnt,
  output logic       seq_err
);

  typedef enum logic [1:0] {WAIT_INIT, ACTIVE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [1:0] w_q, w_d, r_q, r_d;
  logic       n_vld_q, n_vld_d;
  logic       wr_load_q, wr_load_d, rd_load_q, rd_load_d;
  logic [7:0] rep_q, rep_d, drop_q, drop_d;
  logic       seq_err_q, seq_err_d;
  logic       inc_rep, inc_drop;
`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
  logic [1:0] s_q, s_d;
`else
  logic       hold_q, hold_d;
`endif

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q   <= WAIT_INIT;
      w_q       <= 2'd0;
      r_q       <= 2'd1;
      n_vld_q   <= 1'b0;
      wr_load_q <= 1'b0;
      rd_load_q <= 1'b0;
      rep_q     <= '0;
      drop_q    <= '0;
      seq_err_q <= 1'b0;
`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
      s_q       <= 2'd2;
`else
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      r_q       <= r_d;
      n_vld_q   <= n_vld_d;
      wr_load_q <= wr_load_d;
      rd_load_q <= rd_load_d;
      rep_q     <= rep_d;
      drop_q    <= drop_d;
      seq_err_q <= seq_err_d;
`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
      s_q       <= s_d;
`else
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    r_d       = r_q;
    n_vld_d   = n_vld_q;
    wr_load_d = 1'b0;
    rd_load_d = 1'b0;
    seq_err_d = seq_err_q;
    inc_rep   = 1'b0;
    inc_drop  = 1'b0;
`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
    s_d       = s_q;
`else
    hold_d    = hold_q;
`endif
    case (state_q)
      WAIT_INIT: begin
        if (sdram_init_done) begin
          state_d   = ACTIVE;
          wr_load_d = 1'b1;
          rd_load_d = 1'b1;
        end
      end
      default: begin
        if (!sdram_init_done) begin
          // Losing init keeps bank roles but forgets any pending frame.
          state_d = WAIT_INIT;
          n_vld_d = 1'b0;
`ifndef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
          hold_d  = 1'b0;
`endif
        end else begin
`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
          if (frame_write_done && rd_frame_req) begin
            w_d       = s_q;
            r_d       = w_q;
            s_d       = r_q;
            n_vld_d   = 1'b0;
            wr_load_d = 1'b1;
            rd_load_d = 1'b1;
            inc_drop  = n_vld_q;
          end else if (frame_write_done) begin
            s_d       = w_q;
            w_d       = s_q;
            n_vld_d   = 1'b1;
            wr_load_d = 1'b1;
            inc_drop  = n_vld_q;
          end else if (rd_frame_req) begin
            rd_load_d = 1'b1;
            if (n_vld_q) begin
              r_d     = s_q;
              s_d     = r_q;
              n_vld_d = 1'b0;
            end else begin
              inc_rep = 1'b1;
            end
          end
`else
          if (state_q == HOLD) begin
            if (frame_write_done) seq_err_d = 1'b1;
            if (rd_frame_req) begin
              w_d       = r_q;
              r_d       = w_q;
              n_vld_d   = 1'b0;
              hold_d    = 1'b0;
              wr_load_d = 1'b1;
              rd_load_d = 1'b1;
              state_d   = ACTIVE;
            end
          end else if (frame_write_done && rd_frame_req) begin
            w_d       = r_q;
            r_d       = w_q;
            n_vld_d   = 1'b0;
            wr_load_d = 1'b1;
            rd_load_d = 1'b1;
          end else if (frame_write_done) begin
            n_vld_d = 1'b1;
            hold_d  = 1'b1;
            state_d = HOLD;
          end else if (rd_frame_req) begin
            rd_load_d = 1'b1;
            inc_rep   = 1'b1;
          end
`endif
        end
      end
    endcase
    rep_d  = (inc_rep  && rep_q  != 8'hFF) ? rep_q  + 8'd1 : rep_q;
    drop_d = (inc_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  assign wr_bank    = w_q;
  assign rd_bank    = r_q;
  assign wr_load    = wr_load_q;
  assign rd_load    = rd_load_q;
  assign repeat_cnt = rep_q;
  assign drop_cnt   = drop_q;
  assign seq_err    = seq_err_q;
`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
  assign wr_hold    = 1'b0;
`else
  assign wr_hold    = hold_q;
`endif

endmodule

// File: tb/tb_sdram_bank_sched.sv
// Directed bench for sdram_bank_sched; follows SDRAM_BANK_SCHED_TRIPLE_BUF_EN like the RTL.
module tb_sdram_bank_sched;

  logic       clk_ref = 1'b0;
  logic       rst = 1'b1;
  logic       sdram_init_done = 1'b0;
  logic       frame_write_done = 1'b0;
  logic       rd_frame_req = 1'b0;
  logic [1:0] wr_bank, rd_bank;
  logic       wr_load, rd_load, wr_hold, seq_err;
  logic [7:0] repeat_cnt, drop_cnt;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  sdram_bank_sched dut (
    .clk_ref          (clk_ref),
    .rst              (rst),
    .sdram_init_done  (sdram_init_done),
    .frame_write_done (frame_write_done),
    .rd_frame_req     (rd_frame_req),
    .wr_bank          (wr_bank),
    .rd_bank          (rd_bank),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .wr_hold          (wr_hold),
    .repeat_cnt       (repeat_cnt),
    .drop_cnt         (drop_cnt),
    .seq_err          (seq_err)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic ev(input logic wd, input logic rq);
    frame_write_done = wd;
    rd_frame_req     = rq;
    tick();
    frame_write_done = 1'b0;
    rd_frame_req     = 1'b0;
  endtask

  task automatic reset_and_init();
    rst = 1'b1;
    sdram_init_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sdram_init_done = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_loads", {wr_load, rd_load}, 0);
    chk("rst_hold", wr_hold, 0);
    chk("rst_cnts", {repeat_cnt, drop_cnt}, 0);
    chk("rst_seq_err", seq_err, 0);
    rst = 1'b0;
    ev(1'b1, 1'b1);
    chk("no_init_ignored", {wr_load, rd_load, wr_bank, rd_bank}, 4'b0001);
    sdram_init_done = 1'b1;
    tick();
    chk("init_loads", {wr_load, rd_load}, 2'b11);
    chk("init_banks", {wr_bank, rd_bank}, 4'b0001);
    tick();
    chk("init_loads_pulse", {wr_load, rd_load}, 2'b00);

`ifdef SDRAM_BANK_SCHED_TRIPLE_BUF_EN
    ev(1'b1, 1'b0);
    chk("t_wd_banks", {wr_bank, rd_bank}, 4'b1001);
    chk("t_wd_loads", {wr_load, rd_load}, 2'b10);
    repeat (5) tick();
    ev(1'b0, 1'b1);
    chk("t_rd_banks", {wr_bank, rd_bank}, 4'b1000);
    chk("t_rd_loads", {wr_load, rd_load}, 2'b01);
    chk("t_rd_repeat", repeat_cnt, 0);
    chk("t_hold_const", wr_hold, 0);

    reset_and_init();
    ev(1'b1, 1'b0);
    ev(1'b1, 1'b0);
    ev(1'b1, 1'b0);
    chk("t_drop2", drop_cnt, 2);
    ev(1'b0, 1'b1);
    chk("t_drop_rd_bank", rd_bank, 0);
    chk("t_drop_wr_bank", wr_bank, 2);

    reset_and_init();
    ev(1'b1, 1'b1);
    chk("t_both_banks", {wr_bank, rd_bank}, 4'b1000);
    chk("t_both_loads", {wr_load, rd_load}, 2'b11);
    chk("t_both_drop", drop_cnt, 0);
`else
    ev(1'b1, 1'b0);
    chk("d_wd_hold", wr_hold, 1);
    chk("d_wd_loads", {wr_load, rd_load}, 2'b00);
    ev(1'b1, 1'b0);
    chk("d_seq_err", seq_err, 1);
    chk("d_hold_kept", wr_hold, 1);
    ev(1'b0, 1'b1);
    chk("d_swap_banks", {wr_bank, rd_bank}, 4'b0100);
    chk("d_swap_hold", wr_hold, 0);
    chk("d_swap_loads", {wr_load, rd_load}, 2'b11);
    ev(1'b0, 1'b1);
    chk("d_repeat", repeat_cnt, 1);
    chk("d_repeat_loads", {wr_load, rd_load}, 2'b01);
    chk("d_repeat_banks", {wr_bank, rd_bank}, 4'b0100);
    ev(1'b1, 1'b1);
    chk("d_both_banks", {wr_bank, rd_bank}, 4'b0001);
    chk("d_both_hold", wr_hold, 0);
    ev(1'b1, 1'b0);
    ev(1'b1, 1'b1);
    chk("d_hold_both_banks", {wr_bank, rd_bank}, 4'b0100);
    chk("d_hold_both_hold", wr_hold, 0);
    ev(1'b1, 1'b0);
    sdram_init_done = 1'b0;
    tick();
    chk("d_initdrop_hold", wr_hold, 0);
    sdram_init_done = 1'b1;
    tick();
    chk("d_reinit_loads", {wr_load, rd_load}, 2'b11);
    chk("d_reinit_banks", {wr_bank, rd_bank}, 4'b0100);
    ev(1'b0, 1'b1);
    chk("d_reinit_nvld_clr", repeat_cnt, 2);
    chk("d_drop_zero", drop_cnt, 0);
`endif

    reset_and_init();
    for (int i = 0; i < 254; i++) ev(1'b0, 1'b1);
    chk("sat_254", repeat_cnt, 254);
    ev(1'b0, 1'b1);
    chk("sat_255", repeat_cnt, 255);
    for (int i = 0; i < 45; i++) ev(1'b0, 1'b1);
    chk("sat_hold", repeat_cnt, 255);
    rst = 1'b1;
    rd_frame_req = 1'b1;
    tick();
    rd_frame_req = 1'b0;
    chk("midrst_cnts", {repeat_cnt, drop_cnt}, 0);
    chk("midrst_loads", {wr_load, rd_load}, 2'b00);
    chk("midrst_banks", {wr_bank, rd_bank}, 4'b0001);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
